// File: rtl/adder_lcd_display.sv
// adder_lcd_display
//   Registered WIDTH-bit adder with carry-in/carry-out. The block also drives an
//   HD44780 LCD in 4-bit mode. After the power-on init it prints
//   "AA+BB+C" on line 1 and "=SSS" on line 2, both in hex. A refresh runs once
//   after init and again whenever {A,B,Cin} differs from what is shown.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   A, B, Cin         adder operands and carry-in
//   S, Cout           registered sum and carry-out (1-cycle latency)
//   SF_D[11:8]        LCD data nibble
//   LCD_E             LCD enable strobe
//   LCD_RS            LCD register select (0 = command, 1 = data)
//   LCD_RW            LCD read/write, tied to write
//   LCD_Enable        held high so the shared StrataFlash stays off the bus
//   busy              high during init and during any refresh
module adder_lcd_display #(
  parameter int WIDTH     = 8,
  parameter int T_POWERON = 750000,
  parameter int E_CYCLES  = 12,
  parameter int T_NIB     = 50,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic [11:8]      SF_D,
  output logic             LCD_E,
  output logic             LCD_RS,
  output logic             LCD_RW,
  output logic             LCD_Enable,
  output logic             busy
);

  localparam int ND = (WIDTH + 3) / 4;  // hex digits per operand
  localparam int SD = (WIDTH + 4) / 4;  // hex digits of {Cout,S}
  localparam int AW = 4 * ND;
  localparam int SW = WIDTH + 1;
  localparam int PW = 4 * SD;
  localparam int L1 = 2 * ND + 3;       // line 1 character count
  localparam int L2 = SD + 1;           // line 2 character count
  localparam int NW = 2 * WIDTH + 1;

  // Nibble writer states
  localparam logic [2:0] W_IDLE  = 3'd0;
  localparam logic [2:0] W_SETUP = 3'd1;
  localparam logic [2:0] W_EHIGH = 3'd2;
  localparam logic [2:0] W_HOLD  = 3'd3;
  localparam logic [2:0] W_WAIT  = 3'd4;

  // Main sequencer states
  localparam logic [2:0] M_PWR      = 3'd0;
  localparam logic [2:0] M_INIT_NIB = 3'd1;
  localparam logic [2:0] M_INIT_CMD = 3'd2;
  localparam logic [2:0] M_IDLE     = 3'd3;
  localparam logic [2:0] M_ADDR1    = 3'd4;
  localparam logic [2:0] M_LINE1    = 3'd5;
  localparam logic [2:0] M_ADDR2    = 3'd6;
  localparam logic [2:0] M_LINE2    = 3'd7;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // ---------------- adder ----------------
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      {r_cout, r_s} <= SW'(A) + SW'(B) + SW'(Cin);
    end
  end

  // ---------------- snapshot and character tables ----------------
  logic [NW-1:0]    r_snap;
  logic [NW-1:0]    w_live;
  logic             w_changed;
  logic [WIDTH-1:0] w_snap_a;
  logic [WIDTH-1:0] w_snap_b;
  logic             w_snap_cin;
  logic [SW-1:0]    w_snap_sum;
  logic [AW-1:0]    w_a_pad;
  logic [AW-1:0]    w_b_pad;
  logic [PW-1:0]    w_s_pad;
  logic [7:0]       w_line1 [16];
  logic [7:0]       w_line2 [16];

  assign w_live     = {A, B, Cin};
  assign w_changed  = (w_live != r_snap);
  assign w_snap_a   = r_snap[NW-1 -: WIDTH];
  assign w_snap_b   = r_snap[WIDTH:1];
  assign w_snap_cin = r_snap[0];
  // The shown sum is recomputed from the snapshot so both lines always agree.
  assign w_snap_sum = SW'(w_snap_a) + SW'(w_snap_b) + SW'(w_snap_cin);
  assign w_a_pad    = AW'(w_snap_a);
  assign w_b_pad    = AW'(w_snap_b);
  assign w_s_pad    = PW'(w_snap_sum);

  for (genvar gi = 0; gi < 16; gi++) begin : g_chars
    if (gi < ND) begin : g_a
      assign w_line1[gi] = hex_char(w_a_pad[4*(ND-1-gi) +: 4]);
    end else if (gi == ND) begin : g_p1
      assign w_line1[gi] = 8'h2B;
    end else if (gi <= 2 * ND) begin : g_b
      assign w_line1[gi] = hex_char(w_b_pad[4*(2*ND-gi) +: 4]);
    end else if (gi == 2 * ND + 1) begin : g_p2
      assign w_line1[gi] = 8'h2B;
    end else if (gi == 2 * ND + 2) begin : g_c
      assign w_line1[gi] = w_snap_cin ? 8'h31 : 8'h30;
    end else begin : g_sp1
      assign w_line1[gi] = 8'h20;
    end

    if (gi == 0) begin : g_eq
      assign w_line2[gi] = 8'h3D;
    end else if (gi <= SD) begin : g_s
      assign w_line2[gi] = hex_char(w_s_pad[4*(SD-gi) +: 4]);
    end else begin : g_sp2
      assign w_line2[gi] = 8'h20;
    end
  end

  // ---------------- main sequencer registers ----------------
  logic [2:0]  r_mstate;
  logic [31:0] r_mcnt;
  logic [3:0]  r_idx;
  logic        r_busy;

  // ---------------- nibble writer ----------------
  logic [2:0]  r_wstate;
  logic [31:0] r_wcnt;
  logic [31:0] r_post;
  logic        r_second;
  logic [3:0]  r_low;
  logic [3:0]  r_sf_d;
  logic        r_rs;
  logic        r_e;

  logic [7:0]  w_byte;
  logic        w_rs;
  logic        w_single;
  logic [31:0] w_wait;
  logic        w_start;
  logic        w_done;

  always_comb begin
    w_byte   = 8'h00;
    w_rs     = 1'b0;
    w_single = 1'b0;
    w_wait   = 32'(T_CMD);
    case (r_mstate)
      M_INIT_NIB: begin
        w_byte   = (r_idx == 4'd3) ? 8'h02 : 8'h03;
        w_single = 1'b1;
      end
      M_INIT_CMD: begin
        case (r_idx)
          4'd0:    w_byte = 8'h28;
          4'd1:    w_byte = 8'h06;
          4'd2:    w_byte = 8'h0C;
          default: w_byte = 8'h01;
        endcase
        if (r_idx == 4'd3) w_wait = 32'(T_CLEAR);
      end
      M_ADDR1: w_byte = 8'h80;
      M_LINE1: begin
        w_byte = w_line1[r_idx];
        w_rs   = 1'b1;
      end
      M_ADDR2: w_byte = 8'hC0;
      M_LINE2: begin
        w_byte = w_line2[r_idx];
        w_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  // A transfer is requested whenever the sequencer sits in a sending state and
  // the writer is free; the writer leaves W_IDLE on the same edge, so each
  // request is taken exactly once.
  assign w_start = (r_wstate == W_IDLE) && (r_mstate != M_PWR) && (r_mstate != M_IDLE);
  assign w_done  = (r_wstate == W_WAIT) && (r_wcnt == 32'd0) && !r_second;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= '0;
      r_post   <= '0;
      r_second <= 1'b0;
      r_low    <= '0;
      r_sf_d   <= '0;
      r_rs     <= 1'b0;
      r_e      <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_start) begin
            r_rs     <= w_rs;
            r_post   <= w_wait;
            r_low    <= w_byte[3:0];
            r_second <= !w_single;
            r_sf_d   <= w_single ? w_byte[3:0] : w_byte[7:4];
            r_wcnt   <= 32'd1;  // two setup cycles before E rises
            r_wstate <= W_SETUP;
          end
        end
        W_SETUP: begin
          if (r_wcnt == 32'd0) begin
            r_e      <= 1'b1;
            r_wcnt   <= 32'(E_CYCLES - 1);
            r_wstate <= W_EHIGH;
          end else begin
            r_wcnt <= r_wcnt - 32'd1;
          end
        end
        W_EHIGH: begin
          if (r_wcnt == 32'd0) begin
            r_e      <= 1'b0;
            r_wstate <= W_HOLD;
          end else begin
            r_wcnt <= r_wcnt - 32'd1;
          end
        end
        W_HOLD: begin
          r_wcnt   <= r_second ? 32'(T_NIB - 1) : (r_post - 32'd1);
          r_wstate <= W_WAIT;
        end
        W_WAIT: begin
          if (r_wcnt == 32'd0) begin
            if (r_second) begin
              r_second <= 1'b0;
              r_sf_d   <= r_low;
              r_wcnt   <= 32'd1;
              r_wstate <= W_SETUP;
            end else begin
              r_wstate <= W_IDLE;
            end
          end else begin
            r_wcnt <= r_wcnt - 32'd1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------- main sequencer ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mstate <= M_PWR;
      r_mcnt   <= '0;
      r_idx    <= '0;
      r_snap   <= '0;
      r_busy   <= 1'b1;
    end else begin
      case (r_mstate)
        M_PWR: begin
          if (r_mcnt == 32'(T_POWERON - 1)) begin
            r_mstate <= M_INIT_NIB;
            r_idx    <= '0;
          end else begin
            r_mcnt <= r_mcnt + 32'd1;
          end
        end
        M_INIT_NIB: begin
          if (w_done) begin
            if (r_idx == 4'd3) begin
              r_mstate <= M_INIT_CMD;
              r_idx    <= '0;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        M_INIT_CMD: begin
          if (w_done) begin
            if (r_idx == 4'd3) begin
              // First refresh is unconditional.
              r_mstate <= M_ADDR1;
              r_snap   <= w_live;
              r_idx    <= '0;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        M_IDLE: begin
          if (w_changed) begin
            r_mstate <= M_ADDR1;
            r_snap   <= w_live;
            r_busy   <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        M_ADDR1: begin
          if (w_done) begin
            r_mstate <= M_LINE1;
            r_idx    <= '0;
          end
        end
        M_LINE1: begin
          if (w_done) begin
            if (r_idx == 4'(L1 - 1)) begin
              r_mstate <= M_ADDR2;
              r_idx    <= '0;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        M_ADDR2: begin
          if (w_done) begin
            r_mstate <= M_LINE2;
            r_idx    <= '0;
          end
        end
        M_LINE2: begin
          if (w_done) begin
            if (r_idx == 4'(L2 - 1)) begin
              r_mstate <= M_IDLE;
              // Inputs that moved during the refresh keep busy high so the
              // follow-up refresh joins this one without a gap.
              r_busy   <= w_changed;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: r_mstate <= M_PWR;
      endcase
    end
  end

  assign S          = r_s;
  assign Cout       = r_cout;
  assign SF_D       = r_sf_d;
  assign LCD_E      = r_e;
  assign LCD_RS     = r_rs;
  assign LCD_RW     = 1'b0;
  assign LCD_Enable = 1'b1;
  assign busy       = r_busy;

endmodule

// File: tb/tb_adder_lcd_display.sv
// Testbench for adder_lcd_display: an 8-bit instance and a 1-bit instance,
// a nibble monitor per instance sampling on the LCD_E falling edge, and a
// scoreboard queue of expected {RS,nibble} values checked in order.
module tb_adder_lcd_display;

  typedef struct packed {
    logic       rs;
    logic [3:0] nib;
    logic [7:0] ew;
  } nib_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int busy_lows = 0;

  // ---- 8-bit instance ----
  logic        rst8 = 1'b1;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00;
  logic        cin8 = 1'b0;
  logic [7:0]  s8;
  logic        cout8;
  logic [11:8] sfd8;
  logic        e8, rs8, rw8, en8, busy8;

  adder_lcd_display #(
    .WIDTH(8), .T_POWERON(20), .E_CYCLES(2), .T_NIB(2), .T_CMD(4), .T_CLEAR(8)
  ) u8 (
    .CLK(clk), .RST(rst8), .A(a8), .B(b8), .Cin(cin8), .S(s8), .Cout(cout8),
    .SF_D(sfd8), .LCD_E(e8), .LCD_RS(rs8), .LCD_RW(rw8), .LCD_Enable(en8), .busy(busy8)
  );

  // ---- 1-bit instance ----
  logic        rst1 = 1'b1;
  logic [0:0]  a1 = 1'b0, b1 = 1'b0;
  logic        cin1 = 1'b0;
  logic [0:0]  s1;
  logic        cout1;
  logic [11:8] sfd1;
  logic        e1, rs1, rw1, en1, busy1;

  adder_lcd_display #(
    .WIDTH(1), .T_POWERON(20), .E_CYCLES(2), .T_NIB(2), .T_CMD(4), .T_CLEAR(8)
  ) u1 (
    .CLK(clk), .RST(rst1), .A(a1), .B(b1), .Cin(cin1), .S(s1), .Cout(cout1),
    .SF_D(sfd1), .LCD_E(e1), .LCD_RS(rs1), .LCD_RW(rw1), .LCD_Enable(en1), .busy(busy1)
  );

  // ---- LCD monitors: log each nibble at the falling edge of LCD_E ----
  nib_t obs8[$];
  nib_t obs1[$];
  logic prev_e8 = 1'b0, prev_e1 = 1'b0;
  int   ew8 = 0, ew1 = 0;
  int   rd8 = 0, rd1 = 0;

  always @(negedge clk) begin
    prev_e8 <= e8;
    ew8     <= e8 ? ew8 + 1 : 0;
    if (prev_e8 && !e8) obs8.push_back({rs8, sfd8, 8'(ew8)});
  end

  always @(negedge clk) begin
    prev_e1 <= e1;
    ew1     <= e1 ? ew1 + 1 : 0;
    if (prev_e1 && !e1) obs1.push_back({rs1, sfd1, 8'(ew1)});
  end

  // ---- scoreboard ----
  logic [4:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_nib(input logic rs, input logic [3:0] n);
    exp_q.push_back({rs, n});
  endtask

  task automatic exp_byte(input logic rs, input logic [7:0] b);
    exp_nib(rs, b[7:4]);
    exp_nib(rs, b[3:0]);
  endtask

  task automatic exp_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_byte(1'b1, s[i]);
  endtask

  task automatic exp_init();
    exp_nib(1'b0, 4'h3);
    exp_nib(1'b0, 4'h3);
    exp_nib(1'b0, 4'h3);
    exp_nib(1'b0, 4'h2);
    exp_byte(1'b0, 8'h28);
    exp_byte(1'b0, 8'h06);
    exp_byte(1'b0, 8'h0C);
    exp_byte(1'b0, 8'h01);
  endtask

  task automatic exp_refresh(input string l1, input string l2);
    exp_byte(1'b0, 8'h80);
    exp_str(l1);
    exp_byte(1'b0, 8'hC0);
    exp_str(l2);
  endtask

  function automatic bit avail(input int which);
    return (which == 8) ? (obs8.size() > rd8) : (obs1.size() > rd1);
  endfunction

  // Compare up to n observed nibbles against the scoreboard, counting any
  // cycle where busy was low while waiting.
  task automatic drain(input int which, input int n);
    nib_t       o;
    logic [4:0] e;
    int         budget;
    int         cnt;
    cnt = 0;
    while (cnt < n && exp_q.size() > 0) begin
      budget = 0;
      while (!avail(which) && budget < 3000) begin
        @(negedge clk);
        budget++;
        if ((which == 8) ? !busy8 : !busy1) busy_lows++;
      end
      tests++;
      assert (budget < 3000) else begin
        fails++;
        $error("FAIL nib_timeout: got no nibble, expected %0h", exp_q[0]);
      end
      if (budget >= 3000) begin
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      if (which == 8) begin
        o = obs8[rd8];
        rd8++;
      end else begin
        o = obs1[rd1];
        rd1++;
      end
      tests++;
      assert ({o.rs, o.nib} === e) else begin
        fails++;
        $error("FAIL nibble(w%0d): got rs/nib %0h, expected %0h", which, {o.rs, o.nib}, e);
      end
      tests++;
      assert (o.ew === 8'd2) else begin
        fails++;
        $error("FAIL e_width(w%0d): got %0d, expected 2", which, o.ew);
      end
      cnt++;
    end
  endtask

  task automatic wait_idle(input int which);
    int budget;
    budget = 0;
    while (((which == 8) ? busy8 : busy1) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("busy_idle", 32'((which == 8) ? busy8 : busy1), 32'd0);
  endtask

  task automatic pwr_wait_check(input int which);
    int highs;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((which == 8) ? e8 : e1) highs++;
    end
    chk("pwr_e_low", 32'(highs), 32'd0);
  endtask

  initial begin
    int budget;

    // ---- reset state (inputs already non-zero) ----
    a8 = 8'h3C; b8 = 8'hA5; cin8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_S", 32'(s8), 32'h0);
    chk("rst_Cout", 32'(cout8), 32'h0);
    chk("rst_SF_D", 32'(sfd8), 32'h0);
    chk("rst_E", 32'(e8), 32'h0);
    chk("rst_RS", 32'(rs8), 32'h0);
    chk("rst_RW", 32'(rw8), 32'h0);
    chk("LCD_Enable", 32'(en8), 32'h1);
    chk("rst_busy", 32'(busy8), 32'h1);

    // ---- init + first display ----
    rst8 = 1'b0;
    exp_init();
    exp_refresh("3C+A5+1", "=0E2");
    @(negedge clk);
    chk("sum_3C_A5", 32'({cout8, s8}), 32'h0E2);
    pwr_wait_check(8);
    busy_lows = 0;
    drain(8, 1000);
    chk("busy_init", 32'(busy_lows), 32'd0);
    wait_idle(8);
    repeat (5) @(negedge clk);
    chk("busy_stays0", 32'(busy8), 32'd0);

    // ---- overflow ----
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
    exp_refresh("FF+01+0", "=100");
    @(negedge clk);
    chk("sum_ovf", 32'({cout8, s8}), 32'h100);
    drain(8, 1000);
    wait_idle(8);

    // ---- change during refresh ----
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    exp_refresh("11+22+0", "=033");
    exp_refresh("10+22+0", "=032");
    busy_lows = 0;
    drain(8, 6);      // address byte plus two characters of line 1
    a8 = 8'h10;
    drain(8, 1000);
    chk("busy_both", 32'(busy_lows), 32'd0);
    wait_idle(8);

    // ---- reset mid-byte ----
    b8 = 8'h23;
    budget = 0;
    while (!e8 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk("e_seen", 32'(e8), 32'd1);
    rst8 = 1'b1;
    @(negedge clk);
    chk("mid_rst_E", 32'(e8), 32'h0);
    chk("mid_rst_SF_D", 32'(sfd8), 32'h0);
    chk("mid_rst_S", 32'(s8), 32'h0);
    chk("mid_rst_busy", 32'(busy8), 32'h1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rd8 = obs8.size();  // drop the abandoned nibble
    rst8 = 1'b0;
    exp_init();
    exp_refresh("10+23+0", "=033");
    pwr_wait_check(8);
    busy_lows = 0;
    drain(8, 1000);
    chk("busy_reinit", 32'(busy_lows), 32'd0);
    wait_idle(8);

    // ---- WIDTH=1 instance ----
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    rst1 = 1'b0;
    exp_init();
    exp_refresh("1+1+1", "=3");
    @(negedge clk);
    chk("w1_sum", 32'({cout1, s1}), 32'h3);
    pwr_wait_check(1);
    drain(1, 1000);
    wait_idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_lcd_display.md
Name: adder_lcd_display

Overview:
- Parametrised successor to the 2-bit adder/LCD demo. Registered WIDTH-bit ripple adder with carry-in and carry-out.
- Owns its HD44780 4-bit LCD interface on the Spartan-3E starter-kit pins.
- Runs the LCD power-on init, then prints operands and sum in hex. It refreshes automatically whenever the inputs change.

Parameters:
- WIDTH, 8, adder operand width; legal range 1..24.
- T_POWERON, 750000, cycles to wait after reset before the first init nibble (15 ms at 50 MHz).
- E_CYCLES, 12, LCD_E high time per nibble, in cycles.
- T_NIB, 50, cycles between the upper and lower nibble of a byte (1 us).
- T_CMD, 2000, cycles after each byte or init nibble (40 us).
- T_CLEAR, 82000, cycles after the Clear Display command (1.64 ms).

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  synchronous, active-high reset.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in.
- S  out  WIDTH  registered sum.
- Cout  out  1  registered carry-out.
- SF_D  out  4 [11:8]  LCD data nibble.
- LCD_E  out  1  LCD enable strobe.
- LCD_RS  out  1  register select: 0 = command, 1 = data.
- LCD_RW  out  1  always 0 (write only).
- LCD_Enable  out  1  constant 1, disables the shared StrataFlash.
- busy  out  1  high while the LCD init or a refresh is in progress.

Behaviour:
- One clock domain, CLK. Reset is synchronous and active-high on RST. All state changes on the rising edge.
- Reset values: S=0, Cout=0, SF_D=0, LCD_E=0, LCD_RS=0, LCD_RW=0, busy=1. Snapshot registers and the pending flag are cleared.
- Adder: {Cout,S} <= A+B+Cin (WIDTH+1 bits, no truncation) every cycle. Latency is 1 cycle, independent of the LCD FSM.
- Nibble write sequence:
  - SF_D and LCD_RS are driven and held 2 cycles.
  - LCD_E is then high for E_CYCLES cycles, then low.
  - SF_D and LCD_RS are held 1 more cycle after LCD_E falls.
- Byte write: upper nibble, wait T_NIB, lower nibble, wait T_CMD. Clear Display uses T_CLEAR instead of T_CMD.
- Main FSM:
  - PWR_WAIT: count T_POWERON cycles.
  - INIT_NIB: send nibbles 0x3, 0x3, 0x3, 0x2 with RS=0, each followed by T_CMD.
  - INIT_CMD: send bytes 0x28, 0x06, 0x0C, 0x01.
  - IDLE.
  - ADDR1: byte 0x80.
  - LINE1: send characters.
  - ADDR2: byte 0xC0.
  - LINE2: send characters.
  - Return to IDLE.
- Digit counts: ND = ceil(WIDTH/4); SD = ceil((WIDTH+1)/4).
- Line 1 contents: ND hex digits of A (MS first), '+', ND hex digits of B, '+', '0' or '1' for Cin. This is 2*ND+3 characters, at most 15.
- Line 2 contents: '=' followed by SD hex digits of {Cout,S}. Unused high bits of the top digit read as 0.
- Hex encoding: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46 (uppercase). Character bytes are sent with RS=1. Positions after the written characters are not rewritten; line lengths are constant, so no stale characters remain.
- Snapshot: on leaving IDLE (entering ADDR1), capture {A,B,Cin}. All characters come from this snapshot, never from the live inputs.
- Refresh trigger:
  - After INIT_CMD completes, one refresh always runs.
  - In IDLE, a refresh starts on the cycle after the live {A,B,Cin} differs from the last displayed snapshot.
  - Inputs changing during a refresh do not disturb it. The comparison in IDLE catches the change afterwards and starts a new refresh.
- busy: 1 from reset through init and during any refresh. It is 0 only in IDLE with the display up to date.
- Reset mid-operation: the transfer is abandoned immediately and LCD_E goes low on the next edge. The full PWR_WAIT and init sequence is rerun.

Test Plan:
- Parameters for all scenarios: WIDTH=8, T_POWERON=20, E_CYCLES=2, T_NIB=2, T_CMD=4, T_CLEAR=8. A bench HD44780 model decodes nibbles on the LCD_E falling edge.
- Init: release RST -> LCD_E stays 0 for 20 cycles. Then the model sees nibbles 3,3,3,2 followed by bytes 28,06,0C,01. busy stays 1 until the first refresh ends.
- Display: A=0x3C, B=0xA5, Cin=1 -> S=0xE2, Cout=0 one cycle after apply. Line1="3C+A5+1", line2="=0E2", then busy=0.
- Overflow: A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1. Line2="=100".
- Change during refresh: switch A to 0x10 in the middle of LINE1 -> the current refresh completes with the old A. A second refresh then shows "10+...", and busy stays 1 across both refreshes.
- Reset mid-byte: assert RST while LCD_E=1 -> next edge gives LCD_E=0, SF_D=0, S=0, busy=1. The init sequence repeats in full.
- WIDTH=1: A=1, B=1, Cin=1 -> S=1, Cout=1. Line1="1+1+1", line2="=3".
